// File: rtl/dram_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the DRAM arbiter and the DRAM model.
// The slave modport is the arbiter's view; master is the requester/DRAM-model view.
interface dram_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;

  logic        dram_en;
  logic        dram_wen;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wmask;
  logic [31:0] dram_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  dram_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output dram_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask
  );
endinterface

// File: rtl/dram_arbiter.sv
// Shares the single DRAM port between the IFU (fetch) and the LSU (load/store).
// One transaction at a time: accept, wait LATENCY-1 cycles, one DRAM strobe,
// one response pulse, back to idle. LSU has priority unless the IFU has been
// passed over STARVE_MAX times in a row while it kept asking.
module dram_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  dram_arbiter_if.slave bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;
  logic        lat_wen;
  logic        lat_lsu;
  logic [31:0] ifu_rdata_q;
  logic [31:0] lsu_rdata_q;

  logic        ifu_forced;
  logic        grant_lsu;
  logic        grant_ifu;
  logic        ifu_ready;
  logic        lsu_ready;
  logic        access;

  // Grant selection, ready generation and next-state decode
  always_comb begin
    state_nxt  = state;
    ifu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    access     = 1'b0;
    ifu_forced = bus.ifu_req_valid && (starve_cnt == SW'(STARVE_MAX));
    grant_lsu  = bus.lsu_req_valid && !ifu_forced;
    grant_ifu  = bus.ifu_req_valid && !grant_lsu;
    case (state)
      IDLE: begin
        lsu_ready = grant_lsu && rst_n;
        ifu_ready = grant_ifu && rst_n;
        if (grant_lsu || grant_ifu) state_nxt = BUSY;
      end
      BUSY: begin
        if (wait_cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the granted request and count down the access latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_wen   <= 1'b0;
      lat_lsu   <= 1'b0;
      wait_cnt  <= '0;
    end else if (lsu_ready) begin
      lat_addr  <= bus.lsu_addr;
      lat_wdata <= bus.lsu_wdata;
      lat_wmask <= bus.lsu_wmask;
      lat_wen   <= bus.lsu_wen;
      lat_lsu   <= 1'b1;
      wait_cnt  <= 4'(LATENCY - 1);
    end else if (ifu_ready) begin
      lat_addr  <= bus.ifu_addr;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_wen   <= 1'b0;
      lat_lsu   <= 1'b0;
      wait_cnt  <= 4'(LATENCY - 1);
    end else if (state == BUSY && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Capture read data into the owner's holding register on the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else if (access) begin
      if (!lat_lsu)     ifu_rdata_q <= bus.dram_rdata;
      else if (lat_wen) lsu_rdata_q <= '0;
      else              lsu_rdata_q <= bus.dram_rdata;
    end
  end

  // Count LSU wins while the IFU keeps waiting; any IFU win or idle IFU clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.ifu_req_valid || ifu_ready) begin
      starve_cnt <= '0;
    end else if (lsu_ready && starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = (state == RESP) && !lat_lsu;
  assign bus.lsu_resp_valid = (state == RESP) && lat_lsu;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.dram_en        = access;
  assign bus.dram_wen       = access && lat_wen;
  assign bus.dram_addr      = access ? lat_addr  : '0;
  assign bus.dram_wdata     = access ? lat_wdata : '0;
  assign bus.dram_wmask     = access ? lat_wmask : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed testbench for dram_arbiter: one DUT at LATENCY=1 with a word memory
// model, one DUT at LATENCY=3 with an address-derived read pattern.
module tb_dram_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dram_arbiter_if bus1();
  dram_arbiter_if bus3();

  dram_arbiter #(.LATENCY(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  dram_arbiter #(.LATENCY(3), .STARVE_MAX(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [31:0] mem [0:255];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational DRAM read for each DUT
  always_comb bus1.dram_rdata = bus1.dram_en ? mem[bus1.dram_addr[9:2]] : 32'h0;
  always_comb bus3.dram_rdata = bus3.dram_en ? (bus3.dram_addr ^ 32'h5A5A_0000) : 32'h0;

  // Masked write commit at the access edge
  always @(posedge clk) begin
    if (bus1.dram_en && bus1.dram_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus1.dram_wmask[b]) mem[bus1.dram_addr[9:2]][8*b +: 8] = bus1.dram_wdata[8*b +: 8];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task test_reset;
    bus1.ifu_req_valid = 1'b1;
    bus1.lsu_req_valid = 1'b1;
    #1;
    total++; if (bus1.ifu_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ifu_ready got=%0b exp=0", bus1.ifu_req_ready); end
    total++; if (bus1.lsu_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_lsu_ready got=%0b exp=0", bus1.lsu_req_ready); end
    total++; if (bus1.dram_en !== 1'b0 || bus1.dram_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_dram got en=%0b addr=%h exp 0", bus1.dram_en, bus1.dram_addr); end
    total++; if (bus1.ifu_resp_valid !== 1'b0 || bus1.lsu_resp_valid !== 1'b0 || bus1.ifu_rdata !== 32'h0 || bus1.lsu_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL rst_resp got irv=%0b lrv=%0b ird=%h lrd=%h exp 0", bus1.ifu_resp_valid, bus1.lsu_resp_valid, bus1.ifu_rdata, bus1.lsu_rdata);
    end
    bus1.ifu_req_valid = 1'b0;
    bus1.lsu_req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
  endtask

  task test_ifu_read;
    @(negedge clk); bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 32'h8000_0000; #1;
    total++; if (bus1.ifu_req_ready !== 1'b1 || bus1.lsu_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL t1_ready got ifu=%0b lsu=%0b exp 1/0", bus1.ifu_req_ready, bus1.lsu_req_ready); end
    @(negedge clk); bus1.ifu_req_valid = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b1 || bus1.dram_wen !== 1'b0 || bus1.dram_addr !== 32'h8000_0000) begin
      bad++; $display("[TB] FAIL t1_dram got en=%0b wen=%0b addr=%h exp 1/0/80000000", bus1.dram_en, bus1.dram_wen, bus1.dram_addr);
    end
    @(negedge clk); #1;
    total++; if (bus1.ifu_resp_valid !== 1'b1 || bus1.ifu_rdata !== 32'h0000_0413) begin bad++; $display("[TB] FAIL t1_resp got v=%0b d=%h exp 1/00000413", bus1.ifu_resp_valid, bus1.ifu_rdata); end
    total++; if (bus1.dram_en !== 1'b0 || bus1.dram_addr !== 32'h0) begin bad++; $display("[TB] FAIL t1_dram_idle got en=%0b addr=%h exp 0", bus1.dram_en, bus1.dram_addr); end
    @(negedge clk); #1;
    total++; if (bus1.ifu_resp_valid !== 1'b0 || bus1.ifu_rdata !== 32'h0000_0413) begin bad++; $display("[TB] FAIL t1_hold got v=%0b d=%h exp 0/00000413", bus1.ifu_resp_valid, bus1.ifu_rdata); end
  endtask

  task test_store_load;
    @(negedge clk);
    bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b1; bus1.lsu_addr = 32'h8000_0010;
    bus1.lsu_wdata = 32'hDEAD_BEEF; bus1.lsu_wmask = 4'b0011; #1;
    total++; if (bus1.lsu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t2_st_ready got=%0b exp=1", bus1.lsu_req_ready); end
    @(negedge clk); bus1.lsu_req_valid = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b1 || bus1.dram_wen !== 1'b1 || bus1.dram_wmask !== 4'b0011 || bus1.dram_wdata !== 32'hDEAD_BEEF || bus1.dram_addr !== 32'h8000_0010) begin
      bad++; $display("[TB] FAIL t2_st_dram got en=%0b wen=%0b m=%b d=%h a=%h", bus1.dram_en, bus1.dram_wen, bus1.dram_wmask, bus1.dram_wdata, bus1.dram_addr);
    end
    @(negedge clk); #1;
    total++; if (bus1.lsu_resp_valid !== 1'b1 || bus1.lsu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL t2_st_resp got v=%0b d=%h exp 1/0", bus1.lsu_resp_valid, bus1.lsu_rdata); end
    @(negedge clk);
    bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b0; bus1.lsu_wdata = 32'h0; bus1.lsu_wmask = 4'b0000; #1;
    total++; if (bus1.lsu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t2_ld_ready got=%0b exp=1", bus1.lsu_req_ready); end
    @(negedge clk); bus1.lsu_req_valid = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b1 || bus1.dram_wen !== 1'b0) begin bad++; $display("[TB] FAIL t2_ld_dram got en=%0b wen=%0b exp 1/0", bus1.dram_en, bus1.dram_wen); end
    @(negedge clk); #1;
    total++; if (bus1.lsu_resp_valid !== 1'b1 || bus1.lsu_rdata !== 32'h0000_BEEF) begin bad++; $display("[TB] FAIL t2_ld_resp got v=%0b d=%h exp 1/0000beef", bus1.lsu_resp_valid, bus1.lsu_rdata); end
    total++; if (bus1.ifu_rdata !== 32'h0000_0413 || bus1.ifu_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t2_ifu_hold got v=%0b d=%h exp 0/00000413", bus1.ifu_resp_valid, bus1.ifu_rdata); end
  endtask

  task test_contention;
    @(negedge clk);
    bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 32'h8000_0004;
    bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b0; bus1.lsu_addr = 32'h8000_0008; #1;
    total++; if (bus1.lsu_req_ready !== 1'b1 || bus1.ifu_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL t3_c0 got lsu=%0b ifu=%0b exp 1/0", bus1.lsu_req_ready, bus1.ifu_req_ready); end
    @(negedge clk); bus1.lsu_req_valid = 1'b0; #1;
    total++; if (bus1.ifu_req_ready !== 1'b0 || bus1.dram_addr !== 32'h8000_0008) begin bad++; $display("[TB] FAIL t3_c1 got ifu_rdy=%0b addr=%h exp 0/80000008", bus1.ifu_req_ready, bus1.dram_addr); end
    @(negedge clk); #1;
    total++; if (bus1.lsu_resp_valid !== 1'b1 || bus1.ifu_resp_valid !== 1'b0 || bus1.lsu_rdata !== 32'h3333_4444 || bus1.ifu_req_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL t3_c2 got lrv=%0b irv=%0b lrd=%h irdy=%0b", bus1.lsu_resp_valid, bus1.ifu_resp_valid, bus1.lsu_rdata, bus1.ifu_req_ready);
    end
    @(negedge clk); #1;
    total++; if (bus1.ifu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t3_c3 got ifu_rdy=%0b exp=1", bus1.ifu_req_ready); end
    @(negedge clk); bus1.ifu_req_valid = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b1 || bus1.dram_addr !== 32'h8000_0004) begin bad++; $display("[TB] FAIL t3_c4 got en=%0b addr=%h exp 1/80000004", bus1.dram_en, bus1.dram_addr); end
    @(negedge clk); #1;
    total++; if (bus1.ifu_resp_valid !== 1'b1 || bus1.lsu_resp_valid !== 1'b0 || bus1.ifu_rdata !== 32'h1111_2222) begin
      bad++; $display("[TB] FAIL t3_c5 got irv=%0b lrv=%0b ird=%h exp 1/0/11112222", bus1.ifu_resp_valid, bus1.lsu_resp_valid, bus1.ifu_rdata);
    end
    @(negedge clk); #1;
    total++; if (bus1.ifu_resp_valid !== 1'b0 || bus1.lsu_resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL t3_c6 got irv=%0b lrv=%0b exp 0/0", bus1.ifu_resp_valid, bus1.lsu_resp_valid); end
  endtask

  task test_starvation;
    byte   seq [6];
    string exp_s;
    int    n;
    exp_s = "LLLLIL";
    n = 0;
    @(negedge clk); @(negedge clk);
    bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 32'h8000_0004;
    bus1.lsu_req_valid = 1'b1; bus1.lsu_wen = 1'b0; bus1.lsu_addr = 32'h8000_0008; #1;
    for (int c = 0; c < 60; c++) begin
      if (bus1.lsu_req_ready === 1'b1) begin seq[n] = "L"; n++; end
      else if (bus1.ifu_req_ready === 1'b1) begin seq[n] = "I"; n++; end
      if (n == 6) break;
      @(negedge clk); #1;
    end
    @(negedge clk);
    bus1.ifu_req_valid = 1'b0; bus1.lsu_req_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (n != 6) begin bad++; $display("[TB] FAIL t4_grant_count got=%0d exp=6", n); end
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        total++; if (seq[i] !== exp_s[i]) begin bad++; $display("[TB] FAIL t4_grant%0d got=%c exp=%c", i, seq[i], exp_s[i]); end
      end
    end
  endtask

  task test_latency3;
    int en_cnt;
    @(negedge clk);
    bus3.lsu_req_valid = 1'b1; bus3.lsu_wen = 1'b0; bus3.lsu_addr = 32'h0000_0100; #1;
    total++; if (bus3.lsu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t5_c0 got lsu_rdy=%0b exp=1", bus3.lsu_req_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin bus3.lsu_req_valid = 1'b0; bus3.ifu_req_valid = 1'b1; bus3.ifu_addr = 32'h0000_0200; end
      #1;
      total++; if (bus3.lsu_req_ready !== 1'b0 || bus3.ifu_req_ready !== 1'b0) begin bad++; $display("[TB] FAIL t5_ready_c%0d got lsu=%0b ifu=%0b exp 0/0", c, bus3.lsu_req_ready, bus3.ifu_req_ready); end
      total++; if (bus3.dram_en !== (c == 3)) begin bad++; $display("[TB] FAIL t5_en_c%0d got=%0b exp=%0b", c, bus3.dram_en, (c == 3)); end
      total++; if (bus3.lsu_resp_valid !== (c == 4)) begin bad++; $display("[TB] FAIL t5_resp_c%0d got=%0b exp=%0b", c, bus3.lsu_resp_valid, (c == 4)); end
    end
    total++; if (bus3.lsu_rdata !== 32'h5A5A_0100) begin bad++; $display("[TB] FAIL t5_rdata got=%h exp=5a5a0100", bus3.lsu_rdata); end
    @(negedge clk); #1;
    total++; if (bus3.ifu_req_ready !== 1'b1) begin bad++; $display("[TB] FAIL t5_c5 got ifu_rdy=%0b exp=1", bus3.ifu_req_ready); end
    bus3.ifu_req_valid = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus3.dram_en === 1'b1 || bus3.ifu_resp_valid === 1'b1) en_cnt++;
    end
    total++; if (en_cnt != 0) begin bad++; $display("[TB] FAIL t5_dropped_req got=%0d exp=0", en_cnt); end
  endtask

  task test_reset_busy;
    int pulses;
    @(negedge clk); bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 32'h8000_0000; #1;
    @(negedge clk); bus1.ifu_req_valid = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b1) begin bad++; $display("[TB] FAIL t6_busy got en=%0b exp=1", bus1.dram_en); end
    rst_n = 1'b0; #1;
    total++; if (bus1.dram_en !== 1'b0 || bus1.dram_addr !== 32'h0 || bus1.ifu_rdata !== 32'h0 || bus1.lsu_rdata !== 32'h0) begin
      bad++; $display("[TB] FAIL t6_rst got en=%0b addr=%h ird=%h lrd=%h exp 0", bus1.dram_en, bus1.dram_addr, bus1.ifu_rdata, bus1.lsu_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus1.dram_en === 1'b1 || bus1.ifu_resp_valid === 1'b1 || bus1.lsu_resp_valid === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL t6_after_rst got=%0d exp=0", pulses); end
    @(negedge clk); bus1.ifu_req_valid = 1'b1; bus1.ifu_addr = 32'h8000_0000; #1;
    @(negedge clk); bus1.ifu_req_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (bus1.ifu_resp_valid !== 1'b1 || bus1.ifu_rdata !== 32'h0000_0413) begin bad++; $display("[TB] FAIL t6_new_req got v=%0b d=%h exp 1/00000413", bus1.ifu_resp_valid, bus1.ifu_rdata); end
  endtask

  // Sequence the scenarios and print the summary
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0413;
    mem[1] = 32'h1111_2222;
    mem[2] = 32'h3333_4444;
    rst_n = 1'b0;
    bus1.ifu_req_valid = 1'b0; bus1.ifu_addr = '0;
    bus1.lsu_req_valid = 1'b0; bus1.lsu_wen = 1'b0; bus1.lsu_addr = '0; bus1.lsu_wdata = '0; bus1.lsu_wmask = '0;
    bus3.ifu_req_valid = 1'b0; bus3.ifu_addr = '0;
    bus3.lsu_req_valid = 1'b0; bus3.lsu_wen = 1'b0; bus3.lsu_addr = '0; bus3.lsu_wdata = '0; bus3.lsu_wmask = '0;
    @(negedge clk);
    test_reset();
    test_ifu_read();
    test_store_load();
    test_contention();
    test_starvation();
    test_latency3();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
